// File: rtl/muldiv_if.sv
// Request/write-back bundle between the register bank read ports, the muldiv execute stage
// and the register bank write port.
interface muldiv_if #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   rsIn;
    logic [WIDTH-1:0]   rtIn;
    logic [REGADDR-1:0] rdAddr;
    logic               busy;
    logic               wEnable;
    logic [REGADDR-1:0] rdSel;
    logic [WIDTH-1:0]   rdIn;
    logic               divByZero;

    modport master (
        output start, op, rsIn, rtIn, rdAddr,
        input  busy, wEnable, rdSel, rdIn, divByZero
    );

    modport slave (
        input  start, op, rsIn, rtIn, rdAddr,
        output busy, wEnable, rdSel, rdIn, divByZero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with a one-cycle register write-back.
// Define MULDIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [REGADDR-1:0]   rdAddr_q, rdSel_q;
    logic [WIDTH-1:0]     rdIn_q, result_d;
    logic                 busy_q, wEnable_q, divByZero_q;

    logic [WIDTH:0]       mulSum;
    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH-1:0]     absA, absB, dbzResult;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quoFix, remFix;
    logic                 capDbz;

`ifdef MULDIV_SIGNED_EN
    logic                 negA_q, negB_q;
`endif

    // One datapath step: multiply and divide both advance every RUN cycle, op selects which is kept.
    always_comb begin
        mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){acc_q[0]}});
        acc_d   = {mulSum, acc_q[WIDTH-1:1]};
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, b_q};
        rem_d   = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
    end

    always_comb begin
        absA = bus.rsIn;
        absB = bus.rtIn;
`ifdef MULDIV_SIGNED_EN
        if (bus.rsIn[WIDTH-1]) absA = -bus.rsIn;
        if (bus.rtIn[WIDTH-1]) absB = -bus.rtIn;
`endif
        capDbz    = bus.op[1] && (bus.rtIn == '0);
        dbzResult = bus.op[0] ? bus.rsIn : '1;
    end

    // Result for the final iteration, with the sign restored on the same cycle it is registered.
    always_comb begin
        prodFix = acc_d;
        quoFix  = quo_d;
        remFix  = rem_d[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (negA_q ^ negB_q) begin
            prodFix = -acc_d;
            quoFix  = -quo_d;
        end
        if (negA_q) remFix = -rem_d[WIDTH-1:0];
`endif
        case (op_q)
            2'b00:   result_d = prodFix[WIDTH-1:0];
            2'b01:   result_d = prodFix[2*WIDTH-1:WIDTH];
            2'b10:   result_d = quoFix;
            default: result_d = remFix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            rdAddr_q    <= '0;
            rdSel_q     <= '0;
            rdIn_q      <= '0;
            busy_q      <= 1'b0;
            wEnable_q   <= 1'b0;
            divByZero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            negA_q      <= 1'b0;
            negB_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    wEnable_q   <= 1'b0;
                    divByZero_q <= 1'b0;
                    if (bus.start) begin
                        op_q     <= bus.op;
                        a_q      <= absA;
                        b_q      <= absB;
                        rdAddr_q <= bus.rdAddr;
                        cnt_q    <= '0;
                        acc_q    <= {{WIDTH{1'b0}}, absB};
                        rem_q    <= '0;
                        quo_q    <= absA;
                        busy_q   <= 1'b1;
`ifdef MULDIV_SIGNED_EN
                        negA_q   <= bus.rsIn[WIDTH-1];
                        negB_q   <= bus.rtIn[WIDTH-1];
`endif
                        // Division by zero skips the iterations and writes back immediately.
                        if (capDbz) begin
                            state_q     <= DONE;
                            wEnable_q   <= 1'b1;
                            divByZero_q <= 1'b1;
                            rdSel_q     <= bus.rdAddr;
                            rdIn_q      <= dbzResult;
                        end else begin
                            state_q     <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_q   <= DONE;
                        wEnable_q <= 1'b1;
                        rdSel_q   <= rdAddr_q;
                        rdIn_q    <= result_d;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    wEnable_q   <= 1'b0;
                    divByZero_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.wEnable   = wEnable_q;
    assign bus.rdSel     = rdSel_q;
    assign bus.rdIn      = rdIn_q;
    assign bus.divByZero = divByZero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs computed with plain
// arithmetic, an independent monitor pops and compares on every wEnable and checks holds/busy.
module tb_muldiv_unit;
    localparam int WIDTH   = 32;
    localparam int REGADDR = 5;

    typedef struct {
        logic [REGADDR-1:0] rd;
        logic [WIDTH-1:0]   data;
        logic               dbz;
        int                 cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(WIDTH), .REGADDR(REGADDR)) bus ();
    muldiv_unit #(.WIDTH(WIDTH), .REGADDR(REGADDR)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t               expQ[$];
    exp_t               monE;
    int                 checks    = 0;
    int                 failures  = 0;
    int                 cycCnt    = 0;
    int                 busyStart = 1;
    int                 busyEnd   = 0;
    logic [WIDTH-1:0]   lastRdIn  = '0;
    logic [REGADDR-1:0] lastRdSel = '0;

    always @(posedge clk) cycCnt++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycCnt);
        end
    endtask

    // Returns {divByZero, result} from the arithmetic definition of each op.
    function automatic logic [WIDTH:0] refModel(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [63:0]      p;
        logic [63:0]      q;
        logic [WIDTH-1:0] res;
`ifdef MULDIV_SIGNED_EN
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        if (b != 0) begin
            q = (op == 2'b10) ? sa / sb : sa % sb;
        end else begin
            q = '0;
        end
`else
        p = {32'b0, a} * {32'b0, b};
        if (b != 0) begin
            q = (op == 2'b10) ? {32'b0, a / b} : {32'b0, a % b};
        end else begin
            q = '0;
        end
`endif
        case (op)
            2'b00:   res = p[31:0];
            2'b01:   res = p[63:32];
            2'b10:   res = (b == 0) ? 32'hFFFF_FFFF : q[31:0];
            default: res = (b == 0) ? a : q[31:0];
        endcase
        return {op[1] && (b == 0), res};
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [REGADDR-1:0] rd);
        int             waitCnt;
        logic [WIDTH:0] r;
        exp_t           e;
        waitCnt = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL idleTimeout: busy=%b, expected 0 within 200 cycles", bus.busy);
            return;
        end
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rsIn   = a;
        bus.rtIn   = b;
        bus.rdAddr = rd;
        r       = refModel(op, a, b);
        e.rd    = rd;
        e.data  = r[WIDTH-1:0];
        e.dbz   = r[WIDTH];
        e.cycle = cycCnt + 1 + (r[WIDTH] ? 0 : WIDTH);
        expQ.push_back(e);
        busyStart = cycCnt + 1;
        busyEnd   = e.cycle;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op     = 2'($urandom);
        bus.rsIn   = $urandom;
        bus.rtIn   = $urandom;
        bus.rdAddr = REGADDR'($urandom);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_wEnable"}, bus.wEnable, 0);
        checkOutput({tag, "_rdSel"}, bus.rdSel, 0);
        checkOutput({tag, "_rdIn"}, bus.rdIn, 0);
        checkOutput({tag, "_divByZero"}, bus.divByZero, 0);
    endtask

    task automatic modelReset();
        expQ.delete();
        lastRdIn  = '0;
        lastRdSel = '0;
        busyStart = 1;
        busyEnd   = 0;
    endtask

    // Monitor: compare every write-back against the scoreboard, and hold/busy on all other cycles.
    always @(posedge clk) begin
        #1;
        if (bus.wEnable === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedWrite: got rdSel=%0d rdIn=0x%0h, expected no write",
                         bus.rdSel, bus.rdIn);
            end else begin
                monE = expQ.pop_front();
                checkOutput("writeCycle", cycCnt, monE.cycle);
                checkOutput("rdSel", bus.rdSel, monE.rd);
                checkOutput("rdIn", bus.rdIn, monE.data);
                checkOutput("divByZero", bus.divByZero, monE.dbz);
                lastRdIn  = monE.data;
                lastRdSel = monE.rd;
            end
        end else begin
            checkOutput("holdRdIn", bus.rdIn, lastRdIn);
            checkOutput("holdRdSel", bus.rdSel, lastRdSel);
            checkOutput("divByZeroIdle", bus.divByZero, 0);
        end
        checkOutput("busy", bus.busy, (cycCnt >= busyStart && cycCnt <= busyEnd) ? 1 : 0);
    end

    initial begin
        int waitCnt;
        logic [1:0]       rop;
        logic [WIDTH-1:0] ra, rb;
        bus.start  = 1'b0;
        bus.op     = '0;
        bus.rsIn   = '0;
        bus.rtIn   = '0;
        bus.rdAddr = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // MUL 7x6 with a second start pulsed mid-RUN that must be ignored.
        applyStimulus(2'b00, 32'd7, 32'd6, 5'd3);
        repeat (3) @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b10;
        bus.rsIn   = 32'd1;
        bus.rtIn   = 32'd0;
        bus.rdAddr = 5'd17;
        @(negedge clk);
        bus.start  = 1'b0;

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        applyStimulus(2'b10, 32'd100, 32'd7, 5'd4);
        applyStimulus(2'b11, 32'd100, 32'd7, 5'd5);
        applyStimulus(2'b10, 32'd5, 32'd0, 5'd6);
        applyStimulus(2'b11, 32'd5, 32'd0, 5'd7);
        applyStimulus(2'b00, 32'd12345, 32'd678, 5'd0);
`ifdef MULDIV_SIGNED_EN
        applyStimulus(2'b10, -32'sd7, 32'd2, 5'd8);
        applyStimulus(2'b11, -32'sd7, 32'd2, 5'd9);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        applyStimulus(2'b01, -32'sd3, 32'd5, 5'd12);
`endif

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom_range(1, 20);
            else rb = $urandom;
            applyStimulus(rop, ra, rb, REGADDR'($urandom));
        end

        // Reset in the middle of RUN: no write-back, all outputs cleared.
        applyStimulus(2'b00, 32'd123, 32'd456, 5'd9);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("abort");

        // Reset and start together: the start is dropped.
        @(negedge clk);
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.op     = 2'b11;
        bus.rsIn   = 32'd5;
        bus.rtIn   = 32'd0;
        bus.rdAddr = 5'd21;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        checkResetOutputs("rstStart");

        applyStimulus(2'b10, 32'hDEAD_BEEF, 32'd3, 5'd31);
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("queueDrained", expQ.size(), 0);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
